picnic_round_scheduler: RTL and testbench

Sequences the per-round engine (round function producing Ch/Cn for one round index j) across all T rounds of a Picnic-on-SM4 signing/verify pass. Drives the engine's level start/end handshake, captures each round's Ch/Cn, and streams them out through a one-entry valid/ready output register. Sits between the top-level sign/verify FSM and the round engine; the downstream consumer is the challenge hash absorber.

---
 rtl/picnic_pkg.sv | 26 ++
 rtl/picnic_out_slot.sv | 42 ++++
 rtl/picnic_round_scheduler.sv | 202 ++++++++++++++++++++
 tb/tb_picnic_round_scheduler.sv | 385 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/picnic_pkg.sv
// Shared definitions for the Picnic round scheduler.
//   T_ROUNDS_DEF   : default number of rounds per pass
//   J_W / D_W      : round index width / Ch,Cn width
//   state_t        : scheduler state encoding
//   round_result_t : one captured round result (index, Ch, Cn)
package picnic_pkg;

  localparam int unsigned T_ROUNDS_DEF = 16;
  localparam int unsigned J_W          = 8;
  localparam int unsigned D_W          = 256;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LAUNCH   = 3'd1,
    ST_WAIT_END = 3'd2,
    ST_RELEASE  = 3'd3,
    ST_DRAIN    = 3'd4
  } state_t;

  typedef struct packed {
    logic [J_W-1:0] j;
    logic [D_W-1:0] ch;
    logic [D_W-1:0] cn;
  } round_result_t;

endpackage

// File: rtl/picnic_out_slot.sv
// One-entry valid/ready output register for round results.
// Ports:
//   clk, reset  : clock, asynchronous active-high reset
//   load        : write load_data into the entry and mark it valid
//   load_data   : round result to store
//   accept      : consumer ready; a valid entry leaves on valid&accept
//   flush       : drop the entry (highest priority)
//   valid       : entry holds a result
//   entry       : stored result, stable while valid and not accepted
//   free_c      : entry can take a load this cycle (empty or leaving)
module picnic_out_slot
  import picnic_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  round_result_t load_data,
  input  logic          accept,
  input  logic          flush,
  output logic          valid,
  output round_result_t entry,
  output logic          free_c
);

  // Entry register: flush beats load, a reload in the accept cycle keeps valid high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid <= 1'b0;
      entry <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      entry <= load_data;
    end else if (valid && accept) begin
      valid <= 1'b0;
    end
  end

  assign free_c = !valid || accept;

endmodule

// File: rtl/picnic_round_scheduler.sv
// Sequences the per-round engine over all T_ROUNDS rounds of a Picnic pass,
// captures each round's Ch/Cn and streams them out through a one-entry slot.
// Optional per-round watchdog: define PICNIC_ROUND_TIMEOUT_EN.
// Ports:
//   clk, reset              : clock, asynchronous active-high reset
//   sched_start/sched_abort : begin a pass (idle only) / abandon the pass
//   rnd_start, rnd_j        : level start and round index to the engine
//   rnd_end, rnd_ch, rnd_cn : engine done (held until rnd_start drops) and results
//   out_valid/out_ready     : output handshake; out_j/out_ch/out_cn payload
//   busy                    : pass in progress
//   sched_done              : one-cycle pulse when the pass completes
//   sched_err               : sticky watchdog error (0 without the watchdog)
module picnic_round_scheduler
  import picnic_pkg::*;
#(
  parameter int unsigned T_ROUNDS = T_ROUNDS_DEF
`ifdef PICNIC_ROUND_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYCLES = 4096
`endif
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           sched_start,
  input  logic           sched_abort,
  output logic           rnd_start,
  output logic [J_W-1:0] rnd_j,
  input  logic           rnd_end,
  input  logic [D_W-1:0] rnd_ch,
  input  logic [D_W-1:0] rnd_cn,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [J_W-1:0] out_j,
  output logic [D_W-1:0] out_ch,
  output logic [D_W-1:0] out_cn,
  output logic           busy,
  output logic           sched_done,
  output logic           sched_err
);

  localparam logic [J_W-1:0] J_LAST = J_W'(T_ROUNDS - 1);

  state_t         state_q, state_d;
  logic [J_W-1:0] j_q, j_d;
  logic           rnd_start_q, rnd_start_d;
  logic           done_q, done_d;
  logic           busy_q;
  logic           armed_q;
  logic           load, flush;
  logic           slot_free_c;
  logic           tmo_hit_c;
  round_result_t  entry;

`ifdef PICNIC_ROUND_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMO_W-1:0] tmo_q;
  logic             err_q;

  // Counts engine-busy cycles of the current round; a stalled capture (rnd_end=1) does not count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmo_q <= '0;
    end else if (state_q == ST_LAUNCH) begin
      tmo_q <= '0;
    end else if (state_q == ST_WAIT_END && !rnd_end) begin
      tmo_q <= tmo_q + TMO_W'(1);
    end
  end

  assign tmo_hit_c = (state_q == ST_WAIT_END) && !rnd_end &&
                     (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));

  // Sticky error: cleared only by a start that is actually taken.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (state_q == ST_IDLE && sched_start) begin
      err_q <= 1'b0;
    end else if (tmo_hit_c && !sched_abort) begin
      err_q <= 1'b1;
    end
  end

  assign sched_err = err_q;
`else
  assign tmo_hit_c = 1'b0;
  assign sched_err = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and next values of the registered outputs.
  always_comb begin
    state_d     = state_q;
    j_d         = j_q;
    rnd_start_d = rnd_start_q;
    done_d      = 1'b0;
    load        = 1'b0;
    flush       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (sched_start) begin
          j_d     = '0;
          state_d = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        rnd_start_d = 1'b1;
        state_d     = ST_WAIT_END;
      end
      ST_WAIT_END: begin
        // armed_q masks an rnd_end left over from before this round's start was seen.
        if (rnd_end && armed_q && slot_free_c) begin
          load        = 1'b1;
          rnd_start_d = 1'b0;
          state_d     = ST_RELEASE;
        end else if (tmo_hit_c) begin
          rnd_start_d = 1'b0;
          flush       = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      ST_RELEASE: begin
        if (!rnd_end) begin
          if (j_q == J_LAST) begin
            state_d = ST_DRAIN;
          end else begin
            j_d     = j_q + J_W'(1);
            state_d = ST_LAUNCH;
          end
        end
      end
      ST_DRAIN: begin
        if (slot_free_c) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: begin
        rnd_start_d = 1'b0;
        flush       = 1'b1;
        state_d     = ST_IDLE;
      end
    endcase

    // Abort wins over everything, including a capture in the same cycle.
    if (sched_abort && state_q != ST_IDLE) begin
      state_d     = ST_IDLE;
      rnd_start_d = 1'b0;
      load        = 1'b0;
      flush       = 1'b1;
      done_d      = 1'b0;
    end
  end

  // Registered outputs and round bookkeeping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      j_q         <= '0;
      rnd_start_q <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      armed_q     <= 1'b0;
    end else begin
      j_q         <= j_d;
      rnd_start_q <= rnd_start_d;
      done_q      <= done_d;
      busy_q      <= (state_d != ST_IDLE);
      armed_q     <= (state_q == ST_WAIT_END);
    end
  end

  picnic_out_slot u_slot (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .load_data ('{j: j_q, ch: rnd_ch, cn: rnd_cn}),
    .accept    (out_ready),
    .flush     (flush),
    .valid     (out_valid),
    .entry     (entry),
    .free_c    (slot_free_c)
  );

  assign rnd_start  = rnd_start_q;
  assign rnd_j      = j_q;
  assign out_j      = entry.j;
  assign out_ch     = entry.ch;
  assign out_cn     = entry.cn;
  assign busy       = busy_q;
  assign sched_done = done_q;

endmodule

// File: tb/tb_picnic_round_scheduler.sv
// Self-checking bench for picnic_round_scheduler (T_ROUNDS=4, engine latency 10).
// A behavioural engine answers each round; a scoreboard queue holds the
// entries each pass must emit, in order, and is checked on every cycle.
module tb_picnic_round_scheduler;

  localparam int T   = 4;
  localparam int LAT = 10;

  typedef struct {
    logic [7:0]   j;
    logic [255:0] ch;
    logic [255:0] cn;
  } exp_t;

  logic         clk;
  logic         reset;
  logic         sched_start;
  logic         sched_abort;
  logic         rnd_start;
  logic [7:0]   rnd_j;
  logic         rnd_end;
  logic [255:0] rnd_ch;
  logic [255:0] rnd_cn;
  logic         out_valid;
  logic         out_ready;
  logic [7:0]   out_j;
  logic [255:0] out_ch;
  logic [255:0] out_cn;
  logic         busy;
  logic         sched_done;
  logic         sched_err;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t q[$];
  bit   m_busy     = 0;
  int   exp_launch = 0;
  int   acc_count  = 0;
  int   done_count = 0;
  bit   prev_start = 0;
  bit   eng_hang   = 0;
  int   eng_cnt    = 0;

  picnic_round_scheduler #(
    .T_ROUNDS(T)
`ifdef PICNIC_ROUND_TIMEOUT_EN
    ,
    .TIMEOUT_CYCLES(64)
`endif
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .sched_start(sched_start),
    .sched_abort(sched_abort),
    .rnd_start  (rnd_start),
    .rnd_j      (rnd_j),
    .rnd_end    (rnd_end),
    .rnd_ch     (rnd_ch),
    .rnd_cn     (rnd_cn),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_j      (out_j),
    .out_ch     (out_ch),
    .out_cn     (out_cn),
    .busy       (busy),
    .sched_done (sched_done),
    .sched_err  (sched_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [255:0] ch_of(input logic [7:0] j);
    return {8{24'hC4C4C4, j}};
  endfunction

  function automatic logic [255:0] cn_of(input logic [7:0] j);
    return {8{j, 24'h5E5E5E}} ^ {32{j}};
  endfunction

  task automatic check_i(input string name, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic check_v(input string name, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Engine: raises rnd_end LAT negedges after it first sees rnd_start, holds it until rnd_start drops.
  initial begin
    rnd_end = 1'b0;
    rnd_ch  = '0;
    rnd_cn  = '0;
    forever begin
      @(negedge clk);
      if (reset || !rnd_start) begin
        eng_cnt = 0;
        if (rnd_end) begin
          rnd_ch = '1;
          rnd_cn = '1;
        end
        rnd_end = 1'b0;
      end else if (!rnd_end && !eng_hang) begin
        eng_cnt++;
        if (eng_cnt >= LAT) begin
          rnd_end = 1'b1;
          rnd_ch  = ch_of(rnd_j);
          rnd_cn  = cn_of(rnd_j);
        end
      end
    end
  end

  // Compare process: launches in order, the entry shown equals the scoreboard front, done only when drained.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (reset) begin
        prev_start = 1'b0;
        continue;
      end
      if (rnd_start && !prev_start) begin
        check_i("launch_j", 32'(rnd_j), exp_launch);
        exp_launch++;
      end
      prev_start = rnd_start;
      if (out_valid && !sched_abort) begin
        if (q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_entry got_j=%0d exp=none", out_j);
        end else begin
          check_i("entry_j", 32'(out_j), 32'(q[0].j));
          check_v("entry_ch", out_ch, q[0].ch);
          check_v("entry_cn", out_cn, q[0].cn);
          if (out_ready) begin
            void'(q.pop_front());
            acc_count++;
          end
        end
      end
      if (sched_done) begin
        done_count++;
        check_i("done_slot_empty", 32'(out_valid), 0);
        check_i("done_all_accepted", q.size(), 0);
        check_i("done_all_launched", exp_launch, T);
        m_busy = 1'b0;
      end
    end
  end

  // A start is taken only when the model is idle; a taken start expects entries 0..T-1.
  task automatic run_start();
    step();
    sched_start = 1'b1;
    if (!m_busy) begin
      m_busy     = 1'b1;
      exp_launch = 0;
      for (int k = 0; k < T; k++) begin
        q.push_back('{j: 8'(k), ch: ch_of(8'(k)), cn: cn_of(8'(k))});
      end
    end
    step();
    sched_start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int bound, output int cycles);
    bit seen = 0;
    cycles = 0;
    while (cycles < bound && !seen) begin
      step();
      cycles++;
      if (sched_done) seen = 1;
    end
    check_i(name, 32'(seen), 1);
  endtask

  task automatic wait_round(input string name, input int jj);
    bit seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      step();
      if (rnd_start && rnd_j == 8'(jj)) seen = 1;
    end
    check_i(name, 32'(seen), 1);
  endtask

  task automatic check_pass_end(input string tag, input int done0, input int acc0);
    step();
    step();
    check_i({tag, "_done_once"}, done_count - done0, 1);
    check_i({tag, "_accepts"}, acc_count - acc0, T);
    check_i({tag, "_busy_after"}, 32'(busy), 0);
    check_i({tag, "_valid_after"}, 32'(out_valid), 0);
  endtask

  task automatic check_zero_outputs(input string tag);
    check_i({tag, "_rnd_start"}, 32'(rnd_start), 0);
    check_i({tag, "_rnd_j"}, 32'(rnd_j), 0);
    check_i({tag, "_out_valid"}, 32'(out_valid), 0);
    check_i({tag, "_out_j"}, 32'(out_j), 0);
    check_v({tag, "_out_ch"}, out_ch, '0);
    check_v({tag, "_out_cn"}, out_cn, '0);
    check_i({tag, "_busy"}, 32'(busy), 0);
    check_i({tag, "_done"}, 32'(sched_done), 0);
    check_i({tag, "_err"}, 32'(sched_err), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout sim_time=%0t limit=200000", $time);
    $fatal(1);
  end

  initial begin
    int cycles;
    int d0;
    int a0;
    bit pinned;
    bit seen;
    logic [255:0] lit_ch0;
    lit_ch0 = 256'hC4C4C400C4C4C400C4C4C400C4C4C400C4C4C400C4C4C400C4C4C400C4C4C400;

    reset       = 1'b1;
    sched_start = 1'b0;
    sched_abort = 1'b0;
    out_ready   = 1'b1;
    step();
    step();
    check_zero_outputs("reset");
    reset = 1'b0;
    step();

    // 1: basic pass; first entry and overall latency pinned by hand.
    d0 = done_count;
    a0 = acc_count;
    run_start();
    cycles = 0;
    seen   = 0;
    pinned = 0;
    while (cycles < 200 && !seen) begin
      step();
      cycles++;
      if (out_valid && !pinned) begin
        pinned = 1;
        check_i("p1_first_valid_cycle", cycles, LAT + 1);
        check_i("p1_first_j", 32'(out_j), 0);
        check_v("p1_first_ch", out_ch, lit_ch0);
      end
      if (sched_done) seen = 1;
    end
    check_i("p1_done_seen", 32'(seen), 1);
    check_i("p1_done_latency", cycles, 49);
    check_pass_end("p1", d0, a0);
    check_i("p1_err", 32'(sched_err), 0);

    // 2: consumer stalls 50 cycles after the first entry.
    out_ready = 1'b0;
    d0 = done_count;
    a0 = acc_count;
    run_start();
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      step();
      if (out_valid) seen = 1;
    end
    check_i("p2_first_entry", 32'(seen), 1);
    repeat (50) step();
    check_i("p2_stall_rnd_start", 32'(rnd_start), 1);
    check_i("p2_stall_rnd_end", 32'(rnd_end), 1);
    check_i("p2_stall_rnd_j", 32'(rnd_j), 1);
    check_i("p2_stall_out_j", 32'(out_j), 0);
    out_ready = 1'b1;
    step();
    check_i("p2_capture_valid", 32'(out_valid), 1);
    check_i("p2_capture_j", 32'(out_j), 1);
    check_i("p2_capture_rnd_start", 32'(rnd_start), 0);
    wait_done("p2_done_seen", 300, cycles);
    check_pass_end("p2", d0, a0);

    // 3: abort in round 2's wait, then a clean restart.
    d0 = done_count;
    run_start();
    wait_round("p3_reach_j2", 2);
    repeat (3) step();
    sched_abort = 1'b1;
    q.delete();
    m_busy = 1'b0;
    step();
    sched_abort = 1'b0;
    check_i("p3_abort_rnd_start", 32'(rnd_start), 0);
    check_i("p3_abort_valid", 32'(out_valid), 0);
    check_i("p3_abort_busy", 32'(busy), 0);
    repeat (20) step();
    check_i("p3_abort_no_done", done_count - d0, 0);
    d0 = done_count;
    a0 = acc_count;
    run_start();
    wait_done("p3_restart_done_seen", 200, cycles);
    check_i("p3_restart_latency", cycles, 49);
    check_pass_end("p3", d0, a0);

    // 4: a start pulse while busy changes nothing.
    d0 = done_count;
    a0 = acc_count;
    run_start();
    repeat (5) step();
    run_start();
    wait_done("p4_done_seen", 200, cycles);
    check_i("p4_latency", cycles, 42);
    check_pass_end("p4", d0, a0);

    // 5: asynchronous reset in round 1.
    run_start();
    wait_round("p5_reach_j1", 1);
    reset = 1'b1;
    q.delete();
    m_busy = 1'b0;
    #1;
    check_zero_outputs("p5_async");
    step();
    step();
    reset = 1'b0;
    step();
    check_i("p5_idle_busy", 32'(busy), 0);
    check_i("p5_idle_rnd_start", 32'(rnd_start), 0);
    d0 = done_count;
    a0 = acc_count;
    run_start();
    wait_done("p5_restart_done_seen", 200, cycles);
    check_i("p5_restart_latency", cycles, 49);
    check_pass_end("p5", d0, a0);

`ifdef PICNIC_ROUND_TIMEOUT_EN
    // 6: engine never answers; the watchdog fires after 64 waiting cycles.
    eng_hang = 1'b1;
    d0 = done_count;
    run_start();
    cycles = 0;
    seen   = 0;
    for (int i = 0; i < 300 && !seen; i++) begin
      if (rnd_start) cycles++;
      if (sched_err) seen = 1;
      else step();
    end
    check_i("p6_err_set", 32'(seen), 1);
    check_i("p6_wait_cycles", cycles, 64);
    check_i("p6_rnd_start", 32'(rnd_start), 0);
    check_i("p6_busy", 32'(busy), 0);
    check_i("p6_valid", 32'(out_valid), 0);
    q.delete();
    m_busy   = 1'b0;
    eng_hang = 1'b0;
    repeat (5) step();
    check_i("p6_no_done", done_count - d0, 0);
    check_i("p6_err_sticky", 32'(sched_err), 1);
    d0 = done_count;
    a0 = acc_count;
    run_start();
    check_i("p6_err_cleared", 32'(sched_err), 0);
    wait_done("p6_restart_done_seen", 200, cycles);
    check_i("p6_restart_latency", cycles, 49);
    check_pass_end("p6", d0, a0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
